// File: rtl/dtr_recovery_ctrl.sv
// dtr_recovery_ctrl
//
// Control FSM for a double-time-redundancy (DTR) output block.
// - In normal operation it alternates save and check cycles.
// - On a failing check it runs a fixed recovery: two rollback cycles, then one substitute
//   cycle, then it resumes normal operation.
// - A retry budget limits how many recoveries may happen back to back. A further fault
//   after the budget is spent parks the block in a sticky halt that only rst clears.
// - A run of clean checks refills the budget.
//
// Every output is decoded from registered state only. There is no combinational path from
// fail to any output.
//
// Parameters
//   MAX_RETRY    : recoveries allowed before the next fault halts (1 .. 2**RETRY_W-1)
//   RETRY_W      : width of the retry counter
//   QUIET_CYCLES : consecutive clean check cycles that clear the retry counter (>= 1)
//   QUIET_W      : width of the quiet counter (must hold QUIET_CYCLES)
//
// Ports
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset, beats every other event
//   fail        : error flag from the output block, sampled only on RUN check cycles
//   save        : first (save) cycle of each DTR pair
//   rollBack    : recovery in progress; output block selects its substitution path
//   subst       : substitution cycle (output block substitutes when rollBack && subst)
//   phase       : 0 = save cycle, 1 = check cycle; 0 outside RUN
//   retry_cnt   : recoveries since the last quiet clear
//   halted      : sticky unrecoverable-error flag
//   fault_total : saturating count of accepted faults (only with DTR_FAULT_STATS_EN)
//
// Optional feature
//   Define DTR_FAULT_STATS_EN to add the 8-bit fault_total output and its counter.

module dtr_recovery_ctrl #(
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned RETRY_W      = 2,
    parameter int unsigned QUIET_CYCLES = 4,
    parameter int unsigned QUIET_W      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fail,
    output logic               save,
    output logic               rollBack,
    output logic               subst,
    output logic               phase,
    output logic [RETRY_W-1:0] retry_cnt,
`ifdef DTR_FAULT_STATS_EN
    output logic [7:0]         fault_total,
`endif
    output logic               halted
);

    localparam logic [RETRY_W-1:0] MaxRetry  = RETRY_W'(MAX_RETRY);
    // Value of the quiet counter at the clean check that completes a quiet run.
    localparam logic [QUIET_W-1:0] QuietLast = QUIET_W'(QUIET_CYCLES - 1);

    typedef enum logic [2:0] {
        StInit,
        StRun,
        StRoll,
        StSubst,
        StHalt
    } state_e;

    state_e             state_q, state_d;
    logic               phase_q, phase_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [QUIET_W-1:0] quiet_q, quiet_d;
    logic               roll_q, roll_d;

    // Events decoded from the current RUN check cycle.
    logic check_cycle;
    logic clean_check;
    logic fault;
    logic can_retry;
    logic quiet_done;

    always_comb begin
        check_cycle = (state_q == StRun) && phase_q;
        clean_check = check_cycle && !fail;
        fault       = check_cycle && fail;
        can_retry   = (retry_q < MaxRetry);
        quiet_done  = clean_check && (quiet_q == QuietLast);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit: state_d = StRun;
            StRun: begin
                if (fault) begin
                    state_d = can_retry ? StRoll : StHalt;
                end
            end
            // roll_q counts the two rollback cycles.
            StRoll: begin
                if (roll_q) begin
                    state_d = StSubst;
                end
            end
            StSubst: state_d = StRun;
            StHalt:  state_d = StHalt;
            default: state_d = StInit;
        endcase
    end

    // Phase toggles only in RUN. Every entry into RUN (from INIT or SUBST) starts on a
    // save cycle because phase is held at 0 everywhere else.
    always_comb begin
        phase_d = 1'b0;
        if (state_q == StRun) begin
            phase_d = ~phase_q;
        end
    end

    // The retry counter saturates at MAX_RETRY: a fault at the limit halts instead.
    always_comb begin
        retry_d = retry_q;
        if (quiet_done) begin
            retry_d = '0;
        end else if (fault && can_retry) begin
            retry_d = retry_q + 1'b1;
        end
    end

    // The quiet counter restarts on every fault and wraps back to 0 when a run completes.
    always_comb begin
        quiet_d = quiet_q;
        if (fault) begin
            quiet_d = '0;
        end else if (clean_check) begin
            quiet_d = quiet_done ? '0 : quiet_q + 1'b1;
        end
    end

    // The rollback cycle counter is held at 0 outside ROLL, so each recovery starts at 0.
    always_comb begin
        roll_d = 1'b0;
        if (state_q == StRoll) begin
            roll_d = ~roll_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            phase_q <= 1'b0;
            retry_q <= '0;
            quiet_q <= '0;
            roll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            retry_q <= retry_d;
            quiet_q <= quiet_d;
            roll_q  <= roll_d;
        end
    end

`ifdef DTR_FAULT_STATS_EN
    // Lifetime fault count. It includes the fault that enters HALT and is never touched
    // by quiet clears.
    logic [7:0] total_q, total_d;

    always_comb begin
        total_d = total_q;
        if (fault && (total_q != 8'hFF)) begin
            total_d = total_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_q <= 8'd0;
        end else begin
            total_q <= total_d;
        end
    end

    assign fault_total = total_q;
`endif

    // Moore output decode.
    always_comb begin
        save      = (state_q == StRun) && !phase_q;
        rollBack  = (state_q == StRoll) || (state_q == StSubst);
        subst     = (state_q == StSubst);
        phase     = phase_q;
        retry_cnt = retry_q;
        halted    = (state_q == StHalt);
    end

endmodule

// File: tb/tb_dtr_recovery_ctrl.sv
// Directed self-checking bench for dtr_recovery_ctrl (default parameters).
// - Inputs are driven on the falling edge.
// - Outputs are checked on the falling edge, after the preceding rising edge has updated
//   the state.
// - Define DTR_FAULT_STATS_EN for both the bench and the design to cover fault_total.

module tb_dtr_recovery_ctrl;

    // Expected {save, rollBack, subst, phase, halted} per state.
    localparam logic [4:0] OutInit = 5'b00000;
    localparam logic [4:0] OutSave = 5'b10000;
    localparam logic [4:0] OutChk  = 5'b00010;
    localparam logic [4:0] OutRoll = 5'b01000;
    localparam logic [4:0] OutSub  = 5'b01100;
    localparam logic [4:0] OutHalt = 5'b00001;

    logic       clk;
    logic       rst;
    logic       fail;
    logic       save;
    logic       roll_back;
    logic       subst;
    logic       phase;
    logic [1:0] retry_cnt;
    logic       halted;
    logic [4:0] outs;
`ifdef DTR_FAULT_STATS_EN
    logic [7:0] fault_total;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    dtr_recovery_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .fail        (fail),
        .save        (save),
        .rollBack    (roll_back),
        .subst       (subst),
        .phase       (phase),
        .retry_cnt   (retry_cnt),
`ifdef DTR_FAULT_STATS_EN
        .fault_total (fault_total),
`endif
        .halted      (halted)
    );

    assign outs = {save, roll_back, subst, phase, halted};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, required $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then check the output vector and the retry count.
    task automatic step_expect(input string tag, input logic [4:0] o, input int r);
        @(negedge clk);
        chk({tag, "/outs"}, 32'(outs), 32'(o));
        chk({tag, "/retry"}, 32'(retry_cnt), 32'(r));
    endtask

    // Start: a save cycle is being observed. End: the next save cycle, with one clean check
    // taken in between.
    task automatic clean_pair(input string tag, input int r_before, input int r_after);
        fail = 1'b0;
        step_expect({tag, "/chk"}, OutChk, r_before);
        step_expect({tag, "/save"}, OutSave, r_after);
    endtask

    // Start: a save cycle is being observed. End: the save cycle after a full recovery.
    task automatic fault_pair(input string tag, input int r_before, input int r_after);
        fail = 1'b0;
        step_expect({tag, "/chk"}, OutChk, r_before);
        fail = 1'b1;
        step_expect({tag, "/roll1"}, OutRoll, r_after);
        fail = 1'b0;
        step_expect({tag, "/roll2"}, OutRoll, r_after);
        step_expect({tag, "/subst"}, OutSub, r_after);
        step_expect({tag, "/save"}, OutSave, r_after);
    endtask

    initial begin
        rst  = 1'b1;
        fail = 1'b0;

        // Reset, then the INIT cycle.
        step_expect("reset", OutInit, 0);
`ifdef DTR_FAULT_STATS_EN
        chk("reset/fault_total", 32'(fault_total), 32'd0);
`endif
        rst = 1'b0;

        // 20 clean cycles: save/check alternate.
        for (int k = 0; k < 20; k++) begin
            step_expect($sformatf("run%0d", k), (k % 2 == 0) ? OutSave : OutChk, 0);
        end

        // fail on a save cycle only is ignored.
        fail = 1'b0;
        step_expect("ign/save", OutSave, 0);
        fail = 1'b1;
        step_expect("ign/chk", OutChk, 0);
        fail = 1'b0;
        step_expect("ign/save2", OutSave, 0);

        // Recovery latency; fail is held high through T+3.
        step_expect("lat/T", OutChk, 0);
        fail = 1'b1;
        step_expect("lat/T+1", OutRoll, 1);
        step_expect("lat/T+2", OutRoll, 1);
        step_expect("lat/T+3", OutSub, 1);
        fail = 1'b0;
        step_expect("lat/T+4", OutSave, 1);
        step_expect("lat/T+5", OutChk, 1);
        step_expect("lat/T+6", OutSave, 1);

        // Faults with fewer than 4 clean checks between them exhaust the budget.
        clean_pair("h/c1", 1, 1);
        fault_pair("h/f2", 1, 2);
        clean_pair("h/c2", 2, 2);
        fault_pair("h/f3", 2, 3);
        step_expect("h/chk4", OutChk, 3);
        fail = 1'b1;
        step_expect("h/halt", OutHalt, 3);
`ifdef DTR_FAULT_STATS_EN
        chk("h/fault_total", 32'(fault_total), 32'd4);
`endif
        for (int k = 0; k < 4; k++) begin
            fail = ~fail;
            step_expect($sformatf("h/stay%0d", k), OutHalt, 3);
        end
        fail = 1'b0;
        rst  = 1'b1;
        step_expect("h/rst", OutInit, 0);
        rst = 1'b0;
        step_expect("q/save0", OutSave, 0);

        // One fault, then 4 clean checks clear the retry count.
        fault_pair("q/f1", 0, 1);
        clean_pair("q/c1", 1, 1);
        clean_pair("q/c2", 1, 1);
        clean_pair("q/c3", 1, 1);
        clean_pair("q/c4", 1, 0);
        fault_pair("q/f2", 0, 1);
        fault_pair("q/f3", 1, 2);
        fault_pair("q/f4", 2, 3);
        clean_pair("q/c5", 3, 3);
        clean_pair("q/c6", 3, 3);
        clean_pair("q/c7", 3, 3);
        clean_pair("q/c8", 3, 0);

        // Reset during ROLL.
        step_expect("rr/chk", OutChk, 0);
        fail = 1'b1;
        step_expect("rr/roll", OutRoll, 1);
        fail = 1'b0;
        rst  = 1'b1;
        step_expect("rr/init", OutInit, 0);
        rst = 1'b0;
        step_expect("rr/save", OutSave, 0);

        // Reset during SUBST.
        step_expect("rs/chk", OutChk, 0);
        fail = 1'b1;
        step_expect("rs/roll1", OutRoll, 1);
        fail = 1'b0;
        step_expect("rs/roll2", OutRoll, 1);
        step_expect("rs/subst", OutSub, 1);
        rst = 1'b1;
        step_expect("rs/init", OutInit, 0);
        rst = 1'b0;
        step_expect("rs/save", OutSave, 0);

`ifdef DTR_FAULT_STATS_EN
        // The fault before the SUBST reset was counted, then cleared by rst.
        chk("st/zero", 32'(fault_total), 32'd0);
        for (int i = 0; i < 300; i++) begin
            fault_pair("st/f", 0, 1);
            chk("st/total", 32'(fault_total), 32'((i + 1 > 255) ? 255 : i + 1));
            clean_pair("st/c1", 1, 1);
            clean_pair("st/c2", 1, 1);
            clean_pair("st/c3", 1, 1);
            clean_pair("st/c4", 1, 0);
        end
        chk("st/sat", 32'(fault_total), 32'd255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
